imm_pack: RTL and testbench

// - Inverse of the immediate extender: takes a 32-bit constant plus a requested extension mode and emits the 16-bit immediate(s) that rebuild it.
// - Emits one beat when the value fits the mode; otherwise a two-beat lui/ori pair (hi16 via LUI mode, lo16 via ZEXT mode).
// - Sits in the instruction-generation path (li/la expansion, branch-offset encoding) ahead of the instruction assembler.

---
 rtl/imm_pack_pkg.sv | 35 +++
 rtl/imm_pack_if.sv | 24 ++
 rtl/imm_fit_check.sv | 30 +++
 rtl/imm_pack.sv | 123 ++++++++++++
 tb/tb_imm_pack.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/imm_pack_pkg.sv
// Shared encodings for the immediate packer: extension modes, FSM states, beat record.
// Optional auto mode selection is enabled by defining IMM_PACK_AUTO_EN.
package imm_pack_pkg;

    localparam logic [1:0] EOP_SEXT = 2'b00;
    localparam logic [1:0] EOP_ZEXT = 2'b01;
    localparam logic [1:0] EOP_LUI  = 2'b10;
    localparam logic [1:0] EOP_BR   = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_e;

    typedef struct packed {
        logic [15:0] imm;
        logic [1:0]  eop;
        logic        last;
        logic        split;
        logic        err;
    } beat_t;

    function automatic beat_t mk_beat(input logic [15:0] imm, input logic [1:0] eop,
                                      input logic last, input logic split, input logic err);
        beat_t b;
        b.imm   = imm;
        b.eop   = eop;
        b.last  = last;
        b.split = split;
        b.err   = err;
        return b;
    endfunction

endpackage

// File: rtl/imm_pack_if.sv
// Request/beat handshake bundle between the instruction generator and imm_pack.
interface imm_pack_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_value;
    logic [1:0]  in_eop;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_imm;
    logic [1:0]  out_eop;
    logic        out_last;
    logic        out_split;
    logic        out_err;

    modport master (
        output in_valid, in_value, in_eop, out_ready,
        input  in_ready, out_valid, out_imm, out_eop, out_last, out_split, out_err
    );

    modport slave (
        input  in_valid, in_value, in_eop, out_ready,
        output in_ready, out_valid, out_imm, out_eop, out_last, out_split, out_err
    );
endinterface

// File: rtl/imm_fit_check.sv
// Combinational check: does a 32-bit constant survive the given extension mode, and
// which 16-bit field rebuilds it.
module imm_fit_check
    import imm_pack_pkg::*;
(
    input  logic [31:0] value_i,
    input  logic [1:0]  eop_i,
    output logic        fit_o,
    output logic [15:0] imm_o
);

    always_comb begin
        fit_o = 1'b0;
        imm_o = value_i[15:0];
        case (eop_i)
            EOP_SEXT: fit_o = (&value_i[31:15]) | ~(|value_i[31:15]);
            EOP_ZEXT: fit_o = ~(|value_i[31:16]);
            EOP_LUI: begin
                fit_o = ~(|value_i[15:0]);
                imm_o = value_i[31:16];
            end
            default: begin
                // branch offsets are word aligned and sign-extended from bit 17
                fit_o = ~(|value_i[1:0]) & ((&value_i[31:17]) | ~(|value_i[31:17]));
                imm_o = value_i[17:2];
            end
        endcase
    end

endmodule

// File: rtl/imm_pack.sv
// Packs a 32-bit constant into one immediate beat, or a lui/ori beat pair when it does
// not fit. IMM_PACK_AUTO_EN: try SEXT, ZEXT, LUI before falling back to a split.
module imm_pack
    import imm_pack_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    imm_pack_if.slave        bus,
    output logic [CNT_W-1:0] split_cnt
);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_BEAT0 = BEAT0;
    localparam logic [1:0] S_BEAT1 = BEAT1;

    logic [3:0]       fit;
    logic [3:0][15:0] fimm;

    for (genvar m = 0; m < 4; m++) begin : g_fit
        imm_fit_check u_fit (
            .value_i (bus.in_value),
            .eop_i   (2'(m)),
            .fit_o   (fit[m]),
            .imm_o   (fimm[m])
        );
    end

    logic [1:0]       state_q, state_d;
    logic             vld_q, vld_d;
    beat_t            beat_q, beat_d;
    logic [15:0]      lo_q, lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    beat_t            first;
    logic             accept, xfer;

    assign bus.in_ready = rst_n && (state_q == S_IDLE);
    assign accept       = bus.in_valid && bus.in_ready;
    assign xfer         = vld_q && bus.out_ready;

    always_comb begin
        first = mk_beat(bus.in_value[31:16], EOP_LUI, 1'b0, 1'b1, 1'b0);
        if (fit[bus.in_eop])
            first = mk_beat(fimm[bus.in_eop], bus.in_eop, 1'b1, 1'b0, 1'b0);
        else if (bus.in_eop == EOP_BR)
            first = mk_beat(16'h0000, EOP_BR, 1'b1, 1'b0, 1'b1);
`ifdef IMM_PACK_AUTO_EN
        else if (fit[0])
            first = mk_beat(fimm[0], EOP_SEXT, 1'b1, 1'b0, 1'b0);
        else if (fit[1])
            first = mk_beat(fimm[1], EOP_ZEXT, 1'b1, 1'b0, 1'b0);
        else if (fit[2])
            first = mk_beat(fimm[2], EOP_LUI, 1'b1, 1'b0, 1'b0);
`endif
    end

    always_comb begin
        state_d = state_q;
        vld_d   = vld_q;
        beat_d  = beat_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_BEAT0;
                    vld_d   = 1'b1;
                    beat_d  = first;
                    lo_d    = bus.in_value[15:0];
                    if (first.split && (cnt_q != '1))
                        cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_BEAT0: begin
                if (xfer) begin
                    if (beat_q.last) begin
                        state_d = S_IDLE;
                        vld_d   = 1'b0;
                    end else begin
                        state_d = S_BEAT1;
                        beat_d  = mk_beat(lo_q, EOP_ZEXT, 1'b1, 1'b1, 1'b0);
                    end
                end
            end
            S_BEAT1: begin
                if (xfer) begin
                    state_d = S_IDLE;
                    vld_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                vld_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            vld_q   <= 1'b0;
            beat_q  <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            beat_q  <= beat_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.out_valid = vld_q;
    assign bus.out_imm   = beat_q.imm;
    assign bus.out_eop   = beat_q.eop;
    assign bus.out_last  = beat_q.last;
    assign bus.out_split = beat_q.split;
    assign bus.out_err   = beat_q.err;
    assign split_cnt     = cnt_q;

endmodule

// File: tb/tb_imm_pack.sv
// Scoreboard bench for imm_pack: expected beats queued at accept, compared on transfer.
module tb_imm_pack;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imm_pack_if bus ();
    imm_pack_if bus2 ();
    logic [15:0] split_cnt;
    logic [1:0]  split_cnt2;

    logic rdy = 1'b1;
    logic bp_en = 1'b0;
    logic bp_bit = 1'b1;
    assign bus.out_ready = bp_en ? bp_bit : rdy;
    always @(posedge clk) begin
        #1 bp_bit = 1'($urandom_range(0, 1));
    end

    imm_pack #(.CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave), .split_cnt(split_cnt));
    imm_pack #(.CNT_W(2))  dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave), .split_cnt(split_cnt2));

    int n_tests = 0;
    int n_fail = 0;
    logic [20:0] sb_q[$];
    logic [15:0] exp_cnt = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void push(input logic [15:0] im, input logic [1:0] e,
                                 input logic l, input logic s, input logic er);
        sb_q.push_back({im, e, l, s, er});
    endfunction

    // reference: range arithmetic on the signed value, independent of bit slicing in the DUT
    function automatic void model(input logic [31:0] v, input logic [1:0] e);
        int signed sv;
        bit s_ok, z_ok, l_ok, b_ok, ok;
        logic [31:0] br_imm;
        sv     = v;
        s_ok   = (sv >= -32768) && (sv <= 32767);
        z_ok   = (v <= 32'h0000_FFFF);
        l_ok   = ((v % 65536) == 0);
        b_ok   = ((v % 4) == 0) && (sv >= -131072) && (sv <= 131071);
        br_imm = sv / 4;
        case (e)
            2'd0:    ok = s_ok;
            2'd1:    ok = z_ok;
            2'd2:    ok = l_ok;
            default: ok = b_ok;
        endcase
        if (ok) begin
            if (e == 2'd2)      push(v[31:16], e, 1'b1, 1'b0, 1'b0);
            else if (e == 2'd3) push(br_imm[15:0], e, 1'b1, 1'b0, 1'b0);
            else                push(v[15:0], e, 1'b1, 1'b0, 1'b0);
        end else if (e == 2'd3) begin
            push(16'h0000, 2'd3, 1'b1, 1'b0, 1'b1);
        end else begin
`ifdef IMM_PACK_AUTO_EN
            if (s_ok)      begin push(v[15:0], 2'd0, 1'b1, 1'b0, 1'b0); return; end
            else if (z_ok) begin push(v[15:0], 2'd1, 1'b1, 1'b0, 1'b0); return; end
            else if (l_ok) begin push(v[31:16], 2'd2, 1'b1, 1'b0, 1'b0); return; end
`endif
            push(v[31:16], 2'd2, 1'b0, 1'b1, 1'b0);
            push(v[15:0], 2'd1, 1'b1, 1'b1, 1'b0);
            if (exp_cnt != 16'hFFFF) exp_cnt++;
        end
    endfunction

    logic [20:0] prev_beat;
    logic        prev_stall = 1'b0;
    always @(negedge clk) begin
        logic [20:0] cur;
        cur = {bus.out_imm, bus.out_eop, bus.out_last, bus.out_split, bus.out_err};
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) chk("hold", {11'd0, cur}, {11'd0, prev_beat});
            if (bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) chk("sb_extra", 32'd1, 32'd0);
                else chk("beat", {11'd0, cur}, {11'd0, sb_q.pop_front()});
            end
            prev_stall <= bus.out_valid && !bus.out_ready;
            prev_beat  <= cur;
        end
    end

    task automatic send(input logic [31:0] v, input logic [1:0] e);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_value = v;
        bus.in_eop   = e;
        for (int g = 0; g < 200; g++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                model(v, e);
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_value = $urandom;
        bus.in_eop   = 2'($urandom_range(0, 3));
    endtask

    task automatic drain();
        for (int g = 0; g < 400; g++) begin
            @(negedge clk);
            if (sb_q.size() == 0) break;
        end
        chk("drain", sb_q.size(), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] vals [8] = '{32'hFFFF_8000, 32'h0000_7FFF, 32'h1234_0000, 32'hFFFF_FFFC,
                              32'h0001_FFFC, 32'h0002_0000, 32'h8000_0001, 32'h0000_FFFF};

    initial begin
        bus.in_valid = 1'b0; bus.in_value = '0; bus.in_eop = '0;
        bus2.in_valid = 1'b0; bus2.in_value = '0; bus2.in_eop = '0; bus2.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_imm", bus.out_imm, 16'h0);
        chk("rst_out_eop", bus.out_eop, 2'b00);
        chk("rst_flags", {bus.out_last, bus.out_split, bus.out_err}, 3'b000);
        chk("rst_split_cnt", split_cnt, 16'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", bus.in_ready, 1'b1);

        send(32'hFFFF_8000, 2'b00); drain();
        chk("cnt_sext_fit", split_cnt, exp_cnt);
        chk("cnt_sext_fit_const", split_cnt, 16'd0);
        send(32'h1234_5678, 2'b01); drain();
        chk("cnt_split", split_cnt, 16'd1);
        send(32'h0000_0104, 2'b11); drain();
        send(32'h0000_0102, 2'b11); drain();

        rdy = 1'b0;
        send(32'h0000_9000, 2'b00);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rdy = 1'b1;
        drain();
        chk("cnt_stall", split_cnt, exp_cnt);

        bp_en = 1'b1;
        for (int i = 0; i < 24; i++) begin
            if (i < 8) send(vals[i], 2'($urandom_range(0, 3)));
            else       send($urandom, 2'($urandom_range(0, 3)));
        end
        drain();
        bp_en = 1'b0;
        chk("cnt_random", split_cnt, exp_cnt);

        send(32'hABCD_0001, 2'b00);
        for (int g = 0; g < 100; g++) begin
            @(negedge clk);
            if (sb_q.size() <= 1) break;
        end
        chk("beat0_seen", sb_q.size(), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", bus.out_valid, 1'b0);
        chk("midrst_cnt", split_cnt, 16'd0);
        sb_q.delete();
        exp_cnt = '0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready", bus.in_ready, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("midrst_no_beat1", bus.out_valid, 1'b0);
        end
        send(32'h0000_0104, 2'b11); drain();

        for (int i = 0; i < 4; i++) begin
            bit ok;
            ok = 1'b0;
            @(posedge clk); #1;
            bus2.in_valid = 1'b1;
            bus2.in_value = 32'h1234_5678;
            bus2.in_eop   = 2'b01;
            for (int g = 0; g < 50; g++) begin
                @(negedge clk);
                if (bus2.in_ready) begin ok = 1'b1; break; end
            end
            if (!ok) chk("sat_accept_timeout", 32'd0, 32'd1);
            @(posedge clk); #1;
            bus2.in_valid = 1'b0;
            chk("sat_cnt", split_cnt2, (i < 3) ? 2'(i + 1) : 2'd3);
        end

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
